// File: rtl/layer_loader.sv
// layer_loader: unpacks host words into image/conv/dense RAM writes via a 2-entry FIFO
//   clk, reset (sync, active-low)
//   ctrl_en/ctrl_data : control word ([31] start, [30] abort, [17:16] target, [15:0] length)
//   wr_en/wr_data     : payload word, wr_ready = FIFO not full
//   wren0..3/data0..3/image_ram_addr : image bank ports (bank k gets byte k)
//   wren_conv/data_conv/conv_ram_addr, wren_dense/data_dense/dense_ram_addr : parameter RAM ports
//   busy, done (one-cycle pulse), err (sticky)
module layer_loader #(
    parameter int IMG_AW     = 10,
    parameter int PAR_AW     = 15,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrl_en,
    input  logic [31:0]       ctrl_data,
    input  logic              wr_en,
    input  logic [31:0]       wr_data,
    output logic              wr_ready,
    output logic              wren0,
    output logic              wren1,
    output logic              wren2,
    output logic              wren3,
    output logic [7:0]        data0,
    output logic [7:0]        data1,
    output logic [7:0]        data2,
    output logic [7:0]        data3,
    output logic [IMG_AW-1:0] image_ram_addr,
    output logic              wren_conv,
    output logic              wren_dense,
    output logic [7:0]        data_conv,
    output logic [7:0]        data_dense,
    output logic [PAR_AW-1:0] conv_ram_addr,
    output logic [PAR_AW-1:0] dense_ram_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, LOAD_IMG, LOAD_PAR} state_t;
    localparam logic [16:0] IMG_MAX = 17'(2**IMG_AW);
    localparam logic [16:0] PAR_MAX = 17'(2**PAR_AW);
    state_t state_q, state_d;
    logic [1:0]  tgt_q, tgt_d;
    logic [15:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
    logic        fin_q, fin_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [1:0]  fcnt_q, fcnt_d;
    logic        wp_q, wp_d, rp_q, rp_d;
    logic [31:0] mem_q [FIFO_DEPTH];
    logic        img_we_q, img_we_d, conv_we_d, dense_we_d;
    logic [31:0] img_data_q, img_data_d;
    logic [7:0]  conv_data_d, dense_data_d, par_byte;
    logic [IMG_AW-1:0] img_addr_d;
    logic [PAR_AW-1:0] conv_addr_d, dense_addr_d;
    logic        done_d, err_d, ready_d, busy_d;
    logic        start, abort, c_ok, push, pop, avail, issue, last, flush;
    logic [1:0]  c_tgt;
    logic [15:0] c_len;
    logic [31:0] head;
    logic        unused_ctrl;
    assign unused_ctrl = ^ctrl_data[29:18];
    assign start   = ctrl_en && ctrl_data[31];
    assign abort   = ctrl_en && ctrl_data[30];
    assign c_tgt   = ctrl_data[17:16];
    assign c_len   = ctrl_data[15:0];
    assign c_ok    = (c_tgt == 2'd0) ? ({1'b0, c_len} <= IMG_MAX)
                                     : (c_tgt != 2'd3 && {1'b0, c_len} <= PAR_MAX);
    assign push    = wr_en && wr_ready && state_q != IDLE;
    // An empty FIFO forwards the incoming word so it reaches the RAM ports one edge after wr_en
    assign head    = (fcnt_q == 2'd0) ? wr_data : mem_q[rp_q];
    assign avail   = fcnt_q != 2'd0 || push;
    assign issue   = state_q != IDLE && !fin_q && avail && !abort;
    assign cnt_inc = cnt_q + 16'd1;
    assign last    = cnt_inc == len_q;
    assign par_byte = head[{bidx_q, 3'b000} +: 8];
    // A parameter word stays in the FIFO until its last used byte has been issued
    assign pop     = issue && (state_q == LOAD_IMG || bidx_q == 2'd3 || last);
    assign flush   = abort || fin_q;
    assign {wren3, wren2, wren1, wren0} = {4{img_we_q}};
    assign {data3, data2, data1, data0} = img_data_q;
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        fin_d        = fin_q;
        bidx_d       = bidx_q;
        fcnt_d       = fcnt_q + 2'(push) - 2'(pop);
        wp_d         = wp_q ^ push;
        rp_d         = rp_q ^ pop;
        img_we_d     = 1'b0;
        conv_we_d    = 1'b0;
        dense_we_d   = 1'b0;
        img_data_d   = img_data_q;
        conv_data_d  = data_conv;
        dense_data_d = data_dense;
        img_addr_d   = image_ram_addr;
        conv_addr_d  = conv_ram_addr;
        dense_addr_d = dense_ram_addr;
        done_d       = 1'b0;
        err_d        = err;
        if (issue) begin
            cnt_d  = cnt_inc;
            fin_d  = last;
            bidx_d = pop ? 2'd0 : bidx_q + 2'd1;
            if (state_q == LOAD_IMG) begin
                img_we_d   = 1'b1;
                img_data_d = head;
                img_addr_d = cnt_q[IMG_AW-1:0];
            end else if (tgt_q == 2'd1) begin
                conv_we_d   = 1'b1;
                conv_data_d = par_byte;
                conv_addr_d = cnt_q[PAR_AW-1:0];
            end else begin
                dense_we_d   = 1'b1;
                dense_data_d = par_byte;
                dense_addr_d = cnt_q[PAR_AW-1:0];
            end
        end
        // fin_q marks the cycle after the final write: report done and drop leftover words
        if (flush) begin
            state_d = IDLE;
            fcnt_d  = 2'd0;
            wp_d    = 1'b0;
            rp_d    = 1'b0;
            bidx_d  = 2'd0;
            fin_d   = 1'b0;
            done_d  = !abort;
        end
        if (start && !abort) begin
            if (state_q != IDLE || !c_ok) begin
                err_d = 1'b1;
            end else begin
                tgt_d  = c_tgt;
                len_d  = c_len;
                cnt_d  = 16'd0;
                bidx_d = 2'd0;
                fin_d  = 1'b0;
                err_d  = 1'b0;
                img_addr_d   = (c_tgt == 2'd0) ? '0 : img_addr_d;
                conv_addr_d  = (c_tgt == 2'd1) ? '0 : conv_addr_d;
                dense_addr_d = (c_tgt == 2'd2) ? '0 : dense_addr_d;
                done_d  = c_len == 16'd0;
                state_d = (c_len == 16'd0) ? IDLE : (c_tgt == 2'd0) ? LOAD_IMG : LOAD_PAR;
            end
        end
        if (wr_en && (state_q == IDLE || !wr_ready)) err_d = 1'b1;
        ready_d = fcnt_d < 2'(FIFO_DEPTH);
        busy_d  = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            tgt_q          <= 2'd0;
            len_q          <= 16'd0;
            cnt_q          <= 16'd0;
            fin_q          <= 1'b0;
            bidx_q         <= 2'd0;
            fcnt_q         <= 2'd0;
            wp_q           <= 1'b0;
            rp_q           <= 1'b0;
            img_we_q       <= 1'b0;
            img_data_q     <= 32'd0;
            image_ram_addr <= '0;
            wren_conv      <= 1'b0;
            wren_dense     <= 1'b0;
            data_conv      <= 8'd0;
            data_dense     <= 8'd0;
            conv_ram_addr  <= '0;
            dense_ram_addr <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
            busy           <= 1'b0;
            wr_ready       <= 1'b1;
        end else begin
            state_q        <= state_d;
            tgt_q          <= tgt_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            fin_q          <= fin_d;
            bidx_q         <= bidx_d;
            fcnt_q         <= fcnt_d;
            wp_q           <= wp_d;
            rp_q           <= rp_d;
            img_we_q       <= img_we_d;
            img_data_q     <= img_data_d;
            image_ram_addr <= img_addr_d;
            wren_conv      <= conv_we_d;
            wren_dense     <= dense_we_d;
            data_conv      <= conv_data_d;
            data_dense     <= dense_data_d;
            conv_ram_addr  <= conv_addr_d;
            dense_ram_addr <= dense_addr_d;
            done           <= done_d;
            err            <= err_d;
            busy           <= busy_d;
            wr_ready       <= ready_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= wr_data;
    end
endmodule

// File: tb/tb_layer_loader.sv
// tb_layer_loader: directed self-checking bench for layer_loader
module tb_layer_loader;
    logic        clk, reset, ctrl_en, wr_en;
    logic [31:0] ctrl_data, wr_data;
    logic        wr_ready, wren0, wren1, wren2, wren3, wren_conv, wren_dense, busy, done, err;
    logic [7:0]  data0, data1, data2, data3, data_conv, data_dense;
    logic [9:0]  image_ram_addr;
    logic [14:0] conv_ram_addr, dense_ram_addr;
    int checks = 0;
    int errors = 0;
    logic [31:0] img_w [$];
    int          img_a [$];
    logic [7:0]  conv_b [$], dense_b [$];
    int          conv_a [$], dense_a [$];
    int          done_cnt = 0;
    layer_loader dut (
        .clk(clk), .reset(reset), .ctrl_en(ctrl_en), .ctrl_data(ctrl_data),
        .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .wren0(wren0), .wren1(wren1), .wren2(wren2), .wren3(wren3),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .image_ram_addr(image_ram_addr),
        .wren_conv(wren_conv), .wren_dense(wren_dense),
        .data_conv(data_conv), .data_dense(data_dense),
        .conv_ram_addr(conv_ram_addr), .dense_ram_addr(dense_ram_addr),
        .busy(busy), .done(done), .err(err)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (wren0) begin
            img_w.push_back({data3, data2, data1, data0});
            img_a.push_back(int'(image_ram_addr));
        end
        if (wren_conv) begin
            conv_b.push_back(data_conv);
            conv_a.push_back(int'(conv_ram_addr));
        end
        if (wren_dense) begin
            dense_b.push_back(data_dense);
            dense_a.push_back(int'(dense_ram_addr));
        end
        if (done) done_cnt++;
    end
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic ctrl(input logic [31:0] d);
        ctrl_en = 1'b1;
        ctrl_data = d;
        step;
        ctrl_en = 1'b0;
        ctrl_data = 32'd0;
    endtask
    task automatic test_reset;
        reset = 1'b0;
        step;
        step;
        checks++;
        if ({wren0, wren1, wren2, wren3, wren_conv, wren_dense, busy, done, err, wr_ready} !== 10'b0000000001) begin
            errors++;
            $display("FAIL reset_flags: got %b expected %b", {wren0, wren1, wren2, wren3, wren_conv, wren_dense, busy, done, err, wr_ready}, 10'b0000000001);
        end
        checks++;
        if ({data0, data1, data2, data3, data_conv, data_dense, image_ram_addr, conv_ram_addr, dense_ram_addr} !== 88'd0) begin
            errors++;
            $display("FAIL reset_data_addr: got %h expected 0", {data0, data1, data2, data3, data_conv, data_dense, image_ram_addr, conv_ram_addr, dense_ram_addr});
        end
        reset = 1'b1;
        step;
    endtask
    task automatic test_image;
        int ib = img_w.size();
        int db = done_cnt;
        logic [31:0] w [3] = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
        ctrl(32'h8000_0003);
        checks++;
        if ({busy, err} !== 2'b10) begin
            errors++;
            $display("FAIL img_start: got busy/err %b expected 10", {busy, err});
        end
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = w[i];
            step;
            checks++;
            if ({wren3, wren2, wren1, wren0, image_ram_addr, data3, data0} !== {4'hf, 10'(i), w[i][31:24], w[i][7:0]}) begin
                errors++;
                $display("FAIL img_write%0d: got wren %b addr %0d d3 %h d0 %h expected 1111 %0d %h %h",
                         i, {wren3, wren2, wren1, wren0}, image_ram_addr, data3, data0, i, w[i][31:24], w[i][7:0]);
            end
        end
        wr_en = 1'b0;
        step;
        checks++;
        if ({done, busy, wren0} !== 3'b100) begin
            errors++;
            $display("FAIL img_done: got done/busy/wren %b expected 100", {done, busy, wren0});
        end
        step;
        checks++;
        if (done !== 1'b0 || img_w.size() - ib != 3 || done_cnt - db != 1) begin
            errors++;
            $display("FAIL img_totals: got done %b writes %0d pulses %0d expected 0 3 1", done, img_w.size() - ib, done_cnt - db);
        end
    endtask
    task automatic test_conv;
        int cb = conv_b.size();
        int nb = dense_b.size();
        int db = done_cnt;
        logic [7:0] e;
        ctrl(32'h8001_0006);
        wr_en = 1'b1;
        wr_data = 32'h44332211;
        step;
        checks++;
        if ({wren_conv, data_conv, conv_ram_addr, wren_dense} !== {1'b1, 8'h11, 15'd0, 1'b0}) begin
            errors++;
            $display("FAIL conv_first: got we %b data %h addr %0d dense %b expected 1 11 0 0", wren_conv, data_conv, conv_ram_addr, wren_dense);
        end
        wr_data = 32'h88776655;
        step;
        wr_en = 1'b0;
        for (int k = 0; k < 40 && done !== 1'b1; k++) step;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL conv_done: got done %b busy %b expected 1 0", done, busy);
        end
        step;
        checks++;
        if (conv_b.size() - cb != 6 || dense_b.size() != nb || done_cnt - db != 1) begin
            errors++;
            $display("FAIL conv_counts: got conv %0d dense %0d pulses %0d expected 6 0 1", conv_b.size() - cb, dense_b.size() - nb, done_cnt - db);
        end
        for (int i = 0; i < 6 && cb + i < conv_b.size(); i++) begin
            e = 8'h11 * 8'(i + 1);
            checks++;
            if (conv_b[cb + i] !== e || conv_a[cb + i] != i) begin
                errors++;
                $display("FAIL conv_byte%0d: got %h@%0d expected %h@%0d", i, conv_b[cb + i], conv_a[cb + i], e, i);
            end
        end
    endtask
    task automatic test_backpressure;
        int nb = dense_b.size();
        int cb = conv_b.size();
        int idx = 2;
        logic [31:0] w [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        ctrl(32'h8002_0010);
        wr_en = 1'b1;
        wr_data = w[0];
        step;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready1: got %b expected 1", wr_ready);
        end
        wr_data = w[1];
        step;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready2: got %b expected 0", wr_ready);
        end
        wr_data = w[2];
        step;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL bp_drop_err: got %b expected 1", err);
        end
        for (int k = 0; k < 100 && idx < 4; k++) begin
            if (wr_ready) begin
                wr_en = 1'b1;
                wr_data = w[idx];
                idx++;
            end else wr_en = 1'b0;
            step;
        end
        wr_en = 1'b0;
        for (int k = 0; k < 60 && done !== 1'b1; k++) step;
        checks++;
        if (done !== 1'b1 || idx != 4) begin
            errors++;
            $display("FAIL bp_done: got done %b sent %0d expected 1 4", done, idx);
        end
        checks++;
        if (dense_b.size() - nb != 16 || conv_b.size() != cb || err !== 1'b1) begin
            errors++;
            $display("FAIL bp_counts: got dense %0d conv %0d err %b expected 16 0 1", dense_b.size() - nb, conv_b.size() - cb, err);
        end
        for (int i = 0; i < 16 && nb + i < dense_b.size(); i++) begin
            checks++;
            if (dense_b[nb + i] !== 8'(i) || dense_a[nb + i] != i) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h@%0d expected %h@%0d", i, dense_b[nb + i], dense_a[nb + i], 8'(i), i);
            end
        end
        step;
    endtask
    task automatic test_abort;
        int cb = conv_b.size();
        int db = done_cnt;
        ctrl(32'h8001_0008);
        wr_en = 1'b1;
        wr_data = 32'hDDCCBBAA;
        step;
        wr_en = 1'b0;
        step;
        step;
        checks++;
        if ({wren_conv, data_conv, conv_ram_addr} !== {1'b1, 8'hCC, 15'd2}) begin
            errors++;
            $display("FAIL abort_third: got %b %h %0d expected 1 cc 2", wren_conv, data_conv, conv_ram_addr);
        end
        ctrl(32'h4000_0000);
        checks++;
        if ({wren_conv, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_stop: got we/busy/done %b expected 000", {wren_conv, busy, done});
        end
        step;
        checks++;
        if (conv_b.size() - cb != 3 || done_cnt != db) begin
            errors++;
            $display("FAIL abort_counts: got bytes %0d pulses %0d expected 3 0", conv_b.size() - cb, done_cnt - db);
        end
        wr_en = 1'b1;
        wr_data = 32'h12345678;
        step;
        wr_en = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL idle_write_err: got %b expected 1", err);
        end
        ctrl(32'h8000_0001);
        checks++;
        if ({err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL restart_clear: got err/busy %b expected 01", {err, busy});
        end
        wr_en = 1'b1;
        wr_data = 32'hA1B2C3D4;
        step;
        wr_en = 1'b0;
        checks++;
        if ({wren0, data0, data3, image_ram_addr} !== {1'b1, 8'hD4, 8'hA1, 10'd0}) begin
            errors++;
            $display("FAIL restart_write: got %b %h %h %0d expected 1 d4 a1 0", wren0, data0, data3, image_ram_addr);
        end
        step;
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL restart_done: got %b expected 10", {done, busy});
        end
        step;
    endtask
    task automatic test_illegal;
        int ib = img_w.size();
        int cb = conv_b.size();
        int nb = dense_b.size();
        int db = done_cnt;
        ctrl(32'h8000_0401);
        checks++;
        if ({err, busy, wren0} !== 3'b100) begin
            errors++;
            $display("FAIL ill_len1025: got %b expected 100", {err, busy, wren0});
        end
        ctrl(32'h8000_0000);
        checks++;
        if ({done, err, busy} !== 3'b100) begin
            errors++;
            $display("FAIL len0_done: got %b expected 100", {done, err, busy});
        end
        step;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL len0_pulse: got %b expected 0", done);
        end
        ctrl(32'h8003_0001);
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL ill_tgt3: got %b expected 10", {err, busy});
        end
        ctrl(32'h8002_8000);
        checks++;
        if ({err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL par_max_ok: got %b expected 01", {err, busy});
        end
        ctrl(32'h4000_0000);
        ctrl(32'h8001_8001);
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL ill_par32769: got %b expected 10", {err, busy});
        end
        ctrl(32'h8000_0400);
        checks++;
        if ({err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL img_max_ok: got %b expected 01", {err, busy});
        end
        ctrl(32'hC000_0001);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL abort_prio_busy: got %b expected 00", {busy, done});
        end
        ctrl(32'hC000_0001);
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL abort_prio_idle: got %b expected 000", {busy, done, err});
        end
        step;
        checks++;
        if (img_w.size() != ib || conv_b.size() != cb || dense_b.size() != nb || done_cnt - db != 1) begin
            errors++;
            $display("FAIL ill_nowrites: got img %0d conv %0d dense %0d pulses %0d expected 0 0 0 1",
                     img_w.size() - ib, conv_b.size() - cb, dense_b.size() - nb, done_cnt - db);
        end
    endtask
    task automatic test_busy_start;
        int ib = img_w.size();
        ctrl(32'h8000_0002);
        wr_en = 1'b1;
        wr_data = 32'hDEADBEEF;
        step;
        ctrl_en = 1'b1;
        ctrl_data = 32'h8000_0005;
        wr_data = 32'h01234567;
        step;
        ctrl_en = 1'b0;
        ctrl_data = 32'd0;
        wr_en = 1'b0;
        checks++;
        if ({err, busy, wren0, image_ram_addr, data0} !== {1'b1, 1'b1, 1'b1, 10'd1, 8'h67}) begin
            errors++;
            $display("FAIL busy_start: got err %b busy %b we %b addr %0d d0 %h expected 1 1 1 1 67", err, busy, wren0, image_ram_addr, data0);
        end
        for (int k = 0; k < 20 && done !== 1'b1; k++) step;
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL busy_start_done: got %b expected 10", {done, busy});
        end
        step;
        checks++;
        if (img_w.size() - ib != 2 || img_w[ib] !== 32'hDEADBEEF || img_w[ib + 1] !== 32'h01234567 || img_a[ib + 1] != 1) begin
            errors++;
            $display("FAIL busy_start_writes: got count %0d expected 2 words deadbeef 01234567", img_w.size() - ib);
        end
    endtask
    task automatic test_reset_mid;
        int ib = img_w.size();
        int db = done_cnt;
        ctrl(32'h8000_0004);
        wr_en = 1'b1;
        wr_data = 32'h11111111;
        step;
        wr_data = 32'h22222222;
        reset = 1'b0;
        step;
        checks++;
        if ({wren0, wren1, wren2, wren3, wren_conv, wren_dense, busy, done, err, wr_ready} !== 10'b0000000001 ||
            {data0, data3, image_ram_addr} !== 26'd0) begin
            errors++;
            $display("FAIL rst_mid: got flags %b data/addr %h expected 0000000001 0",
                     {wren0, wren1, wren2, wren3, wren_conv, wren_dense, busy, done, err, wr_ready}, {data0, data3, image_ram_addr});
        end
        reset = 1'b1;
        wr_en = 1'b0;
        repeat (5) step;
        checks++;
        if (img_w.size() - ib != 1 || done_cnt != db || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got writes %0d pulses %0d busy %b expected 1 0 0", img_w.size() - ib, done_cnt - db, busy);
        end
    endtask
    initial begin
        reset = 1'b0;
        ctrl_en = 1'b0;
        ctrl_data = 32'd0;
        wr_en = 1'b0;
        wr_data = 32'd0;
        test_reset;
        test_image;
        test_conv;
        test_backpressure;
        test_abort;
        test_illegal;
        test_busy_start;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
